// File: rtl/hub75_rx.sv
`default_nettype none
// ============================================================================
// Module   : hub75_rx
// Purpose  : HUB75 panel-side receiver; rebuilds each shifted row as a pixel
//            stream with double-buffered capture. Define
//            HUB75_RX_WIDTH_CHECK_EN to compile in the err_width check.
// Revision : 1.0 - initial release
// ============================================================================
module hub75_rx #(
  parameter int WIDTH = 64,
  parameter int XW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hub_clk,
  input  logic          hub_latch,
  input  logic          hub_oe,
  input  logic [3:0]    hub_addr,
  input  logic [5:0]    hub_rgb,
  input  logic          err_clr,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [3:0]    pix_row,
  output logic [5:0]    pix_rgb,
  output logic          pix_sof,
  output logic          row_done,
  output logic          err_overrun,
  output logic          err_width,
  output logic [7:0]    oe_pulses
);

  localparam logic [XW:0] c_width_cnt = (XW+1)'(WIDTH);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  // [0]/[1] are the two sync stages, [2] is the delayed copy for edge detect
  logic [2:0] r_clk_sync, r_lat_sync, r_oe_sync;
  logic [3:0] r_addr_s1, r_addr_s2;
  logic [5:0] r_rgb_s1, r_rgb_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= '0;
      r_lat_sync <= '0;
      r_oe_sync  <= '0;
      r_addr_s1  <= '0;
      r_addr_s2  <= '0;
      r_rgb_s1   <= '0;
      r_rgb_s2   <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], hub_clk};
      r_lat_sync <= {r_lat_sync[1:0], hub_latch};
      r_oe_sync  <= {r_oe_sync[1:0], hub_oe};
      r_addr_s1  <= hub_addr;
      r_addr_s2  <= r_addr_s1;
      r_rgb_s1   <= hub_rgb;
      r_rgb_s2   <= r_rgb_s1;
    end
  end

  logic w_clk_rise, w_lat_rise, w_oe_rise;
  assign w_clk_rise = r_clk_sync[1] & ~r_clk_sync[2];
  assign w_lat_rise = r_lat_sync[1] & ~r_lat_sync[2];
  assign w_oe_rise  = r_oe_sync[1]  & ~r_oe_sync[2];

  logic [XW:0] r_col, w_col_next, w_n_minus1;
  logic        w_col_full, w_shift;
  assign w_col_full = (r_col == c_width_cnt);
  assign w_shift    = w_clk_rise & ~w_col_full;
  assign w_col_next = r_col + (XW+1)'(w_shift);
  assign w_n_minus1 = w_col_next - (XW+1)'(1);

  logic       r_wsel;
  logic [5:0] r_buf0 [WIDTH];
  logic [5:0] r_buf1 [WIDTH];

  always_ff @(posedge clk) begin
    if (w_shift && !r_wsel) r_buf0[r_col[XW-1:0]] <= r_rgb_s2;
    if (w_shift &&  r_wsel) r_buf1[r_col[XW-1:0]] <= r_rgb_s2;
  end

  state_t        r_state;
  logic [XW-1:0] r_idx, r_last, w_idx_inc, w_last;
  logic [3:0]    r_row;
  logic [5:0]    r_rgb, w_first_rgb, w_next_rgb;
  logic          r_valid, r_sof, r_row_done, r_err_ovr;

  assign w_idx_inc = r_idx + XW'(1);
  assign w_last    = w_n_minus1[XW-1:0];
  // Column 0 may be written in the very cycle the latch is seen; bypass it.
  assign w_first_rgb = (w_shift && (r_col == '0)) ? r_rgb_s2 :
                       (r_wsel ? r_buf1[0] : r_buf0[0]);
  assign w_next_rgb  = r_wsel ? r_buf0[w_idx_inc] : r_buf1[w_idx_inc];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_wsel     <= 1'b0;
      r_idx      <= '0;
      r_last     <= '0;
      r_row      <= '0;
      r_rgb      <= '0;
      r_valid    <= 1'b0;
      r_sof      <= 1'b0;
      r_row_done <= 1'b0;
      r_err_ovr  <= 1'b0;
    end else begin
      r_row_done <= 1'b0;
      if (err_clr) r_err_ovr <= 1'b0;

      if (r_state == S_DRAIN && pix_ready) begin
        if (r_idx == r_last) begin
          r_state    <= S_IDLE;
          r_valid    <= 1'b0;
          r_sof      <= 1'b0;
          r_row_done <= 1'b1;
        end else begin
          r_idx <= w_idx_inc;
          r_rgb <= w_next_rgb;
          r_sof <= 1'b0;
        end
      end

      if (w_lat_rise) begin
        r_col <= '0;
        if (r_state == S_IDLE) begin
          r_wsel <= ~r_wsel;
          r_last <= w_last;
          if (w_col_next == '0) begin
            r_row_done <= 1'b1;
          end else begin
            r_state <= S_DRAIN;
            r_valid <= 1'b1;
            r_idx   <= '0;
            r_row   <= r_addr_s2;
            r_rgb   <= w_first_rgb;
            r_sof   <= (r_addr_s2 == 4'd0);
          end
        end else begin
          r_err_ovr <= 1'b1;
        end
      end else begin
        r_col <= w_col_next;
      end
    end
  end

`ifdef HUB75_RX_WIDTH_CHECK_EN
  logic r_extra, r_err_wid, w_width_bad;
  assign w_width_bad = w_lat_rise &
                       ((w_col_next != c_width_cnt) | r_extra | (w_clk_rise & w_col_full));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_extra   <= 1'b0;
      r_err_wid <= 1'b0;
    end else begin
      if (w_lat_rise)                   r_extra <= 1'b0;
      else if (w_clk_rise & w_col_full) r_extra <= 1'b1;
      if (w_width_bad)  r_err_wid <= 1'b1;
      else if (err_clr) r_err_wid <= 1'b0;
    end
  end
  assign err_width = r_err_wid;
`else
  assign err_width = 1'b0;
`endif

  logic [7:0] r_oe_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_oe_cnt <= '0;
    else if (w_oe_rise) r_oe_cnt <= r_oe_cnt + 8'd1;
  end

  assign pix_valid   = r_valid;
  assign pix_x       = r_idx;
  assign pix_row     = r_row;
  assign pix_rgb     = r_rgb;
  assign pix_sof     = r_sof;
  assign row_done    = r_row_done;
  assign err_overrun = r_err_ovr;
  assign oe_pulses   = r_oe_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hub75_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_rx
// Purpose  : Self-checking bench for hub75_rx against a queue-based row model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hub75_rx;
  localparam int WIDTH = 64;
  localparam int XW    = 6;

  logic          clk = 1'b0;
  logic          rst, hub_clk, hub_latch, hub_oe, err_clr, pix_ready;
  logic [3:0]    hub_addr;
  logic [5:0]    hub_rgb;
  logic          pix_valid, pix_sof, row_done, err_overrun, err_width;
  logic [XW-1:0] pix_x;
  logic [3:0]    pix_row;
  logic [5:0]    pix_rgb;
  logic [7:0]    oe_pulses;

  hub75_rx #(.WIDTH(WIDTH), .XW(XW)) dut (
    .clk(clk), .rst(rst), .hub_clk(hub_clk), .hub_latch(hub_latch),
    .hub_oe(hub_oe), .hub_addr(hub_addr), .hub_rgb(hub_rgb),
    .err_clr(err_clr), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_row(pix_row), .pix_rgb(pix_rgb), .pix_sof(pix_sof),
    .row_done(row_done), .err_overrun(err_overrun), .err_width(err_width),
    .oe_pulses(oe_pulses)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [5:0] x;
    logic [3:0] row;
    logic [5:0] rgb;
    logic       sof;
  } pix_t;

  pix_t       m_exp[$];
  logic [5:0] m_cols[$];
  bit         m_busy = 0, m_ovr = 0, m_wid = 0;
  int         m_oe = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_exp.delete(); m_cols.delete();
    m_busy = 0; m_ovr = 0; m_wid = 0; m_oe = 0;
  endtask

  // A latch turns the shifted columns into an expected row, or an overrun.
  task automatic model_latch(input logic [3:0] addr, output bit exp_pix);
    int n;
    n = m_cols.size();
`ifdef HUB75_RX_WIDTH_CHECK_EN
    if (n != WIDTH) m_wid = 1;
`endif
    if (n > WIDTH) n = WIDTH;
    exp_pix = 0;
    if (m_busy) m_ovr = 1;
    else if (n > 0) begin
      for (int i = 0; i < n; i++)
        m_exp.push_back('{x: 6'(i), row: addr, rgb: m_cols[i], sof: (i == 0 && addr == 4'd0)});
      m_busy = 1;
      exp_pix = 1;
    end
    m_cols.delete();
  endtask

  task automatic shift_col(input logic [5:0] v);
    hub_rgb = v;
    @(negedge clk);
    hub_clk = 1'b1;
    repeat (3) @(negedge clk);
    hub_clk = 1'b0;
    repeat (3) @(negedge clk);
    m_cols.push_back(v);
  endtask

  task automatic do_latch(input logic [3:0] addr, input bit with_clk, input logic [5:0] v);
    bit exp_pix;
    if (with_clk) begin
      hub_rgb = v;
      @(negedge clk);
      hub_clk = 1'b1;
      m_cols.push_back(v);
    end
    hub_latch = 1'b1;
    model_latch(addr, exp_pix);
    repeat (2) @(negedge clk);
    if (exp_pix) check("latch_latency_early", 32'(pix_valid), 0);
    @(negedge clk);
    if (exp_pix) check("latch_latency", 32'(pix_valid), 1);
    check("err_overrun_after_latch", 32'(err_overrun), 32'(m_ovr));
    check("err_width_after_latch", 32'(err_width), 32'(m_wid));
    hub_latch = 1'b0;
    hub_clk   = 1'b0;
  endtask

  // mode 0: ready high, 1: ready 1,0,1,0..., 2: random. stop_at<0 drains fully.
  task automatic drain(input int mode, input int stop_at);
    int   acc, n, cyc;
    bit   r;
    pix_t e;
    acc = 0; cyc = 0; n = m_exp.size();
    while (acc < n && cyc < 2000 && !(stop_at >= 0 && acc == stop_at)) begin
      case (mode)
        0:       r = 1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      pix_ready = r;
      check("drain_valid", 32'(pix_valid), 1);
      if (!pix_valid) break;
      check("drain_row_done_low", 32'(row_done), 0);
      e = m_exp[0];
      check(r ? "pix_x" : "pix_x_held", 32'(pix_x), 32'(e.x));
      check(r ? "pix_row" : "pix_row_held", 32'(pix_row), 32'(e.row));
      check(r ? "pix_rgb" : "pix_rgb_held", 32'(pix_rgb), 32'(e.rgb));
      check(r ? "pix_sof" : "pix_sof_held", 32'(pix_sof), 32'(e.sof));
      if (r) begin
        void'(m_exp.pop_front());
        acc++;
      end
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 2000) check("drain_timeout", 1, 0);
    if (stop_at < 0) begin
      pix_ready = 1'b0;
      check("row_done_pulse", 32'(row_done), 1);
      check("valid_after_row", 32'(pix_valid), 0);
      m_busy = 0;
      @(negedge clk);
      check("row_done_single", 32'(row_done), 0);
    end
  endtask

  task automatic shift_row(input logic [3:0] addr, input int cols, input bit rnd);
    hub_addr = addr;
    for (int i = 0; i < cols; i++) shift_col(rnd ? 6'($urandom) : 6'(i));
  endtask

  task automatic pulse_oe(input int count);
    for (int i = 0; i < count; i++) begin
      hub_oe = 1'b1;
      repeat (3) @(negedge clk);
      hub_oe = 1'b0;
      repeat (3) @(negedge clk);
      m_oe = (m_oe + 1) % 256;
    end
    repeat (4) @(negedge clk);
    check("oe_pulses", 32'(oe_pulses), 32'(m_oe));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(pix_valid), 0);
    check({tag, "_row_done"}, 32'(row_done), 0);
    check({tag, "_err_overrun"}, 32'(err_overrun), 0);
    check({tag, "_err_width"}, 32'(err_width), 0);
    check({tag, "_oe"}, 32'(oe_pulses), 0);
    check({tag, "_x"}, 32'(pix_x), 0);
    check({tag, "_rgb"}, 32'(pix_rgb), 0);
    check({tag, "_sof"}, 32'(pix_sof), 0);
  endtask

  initial begin
    rst = 1'b1; hub_clk = 0; hub_latch = 0; hub_oe = 0; hub_addr = 0;
    hub_rgb = 0; err_clr = 0; pix_ready = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("after_reset");

    // Full row, rgb = x, ready held high
    shift_row(4'd5, WIDTH, 0);
    do_latch(4'd5, 0, 6'd0);
    drain(0, -1);

    // Same row with ready toggling
    shift_row(4'd5, WIDTH, 0);
    do_latch(4'd5, 0, 6'd0);
    drain(1, -1);

    // Random data, random address, random back-pressure
    begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      shift_row(a, WIDTH, 1);
      do_latch(a, 0, 6'd0);
      drain(2, -1);
    end

    // Short row: 10 columns
    shift_row(4'd3, 10, 1);
    do_latch(4'd3, 0, 6'd0);
    drain(0, -1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    m_wid = 0; m_ovr = 0;
    check("err_width_cleared", 32'(err_width), 0);

    // Shift coinciding with latch belongs to the latched row (8 columns)
    shift_row(4'd12, 7, 1);
    do_latch(4'd12, 1, 6'($urandom));
    drain(0, -1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    m_wid = 0; m_ovr = 0;

    // Overrun: second latch while row 0 is stalled
    shift_row(4'd0, WIDTH, 1);
    do_latch(4'd0, 0, 6'd0);
    check("sof_first_pixel", 32'(pix_sof), 1);
    repeat (3) @(negedge clk);
    shift_row(4'd9, 5, 1);
    do_latch(4'd9, 0, 6'd0);
    check("err_overrun_set", 32'(err_overrun), 1);
    drain(0, -1);
    for (int i = 0; i < 6; i++) begin
      check("second_row_absent", 32'(pix_valid), 0);
      @(negedge clk);
    end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    m_wid = 0; m_ovr = 0;
    check("err_overrun_cleared", 32'(err_overrun), 0);
    check("err_width_cleared2", 32'(err_width), 0);

    // Reset in the middle of a drain
    shift_row(4'd7, WIDTH, 1);
    do_latch(4'd7, 0, 6'd0);
    drain(0, 20);
    #2 rst = 1'b1; pix_ready = 1'b0;
    #1 check_idle_outputs("mid_drain_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    shift_row(4'd2, WIDTH, 1);
    do_latch(4'd2, 0, 6'd0);
    drain(0, -1);

    // Output-enable pulse counter and its wrap
    pulse_oe(3);
    check("oe_three", 32'(oe_pulses), 3);
    pulse_oe(253);
    check("oe_wrap", 32'(oe_pulses), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/hub75_rx.md
# hub75_rx

Panel-side receiver for the HUB75 LED panel interface: samples the shift clock, latch, output-enable, row address and six RGB data lines produced by the panel driver, and rebuilds each shifted row as a pixel stream with column and row coordinates. It sits in the bench/loopback path as the far end of the panel driver. It lets the driver's output be checked in hardware and fed into a frame-compare or frame-buffer block. Capture is double-buffered, so a completed row drains while the next row shifts in.

## Interface
- `WIDTH`, 64: columns per row; legal range 2..64.
- `XW`, 6: width of the column index; 2^XW ≥ WIDTH.
- `clk`  in  1: system clock; all logic on posedge.
- `rst`  in  1: asynchronous, active-high reset.
- `hub_clk`  in  1: panel shift clock; data is sampled on its rising edge.
- `hub_latch`  in  1: row latch; a rising edge ends the row.
- `hub_oe`  in  1: output enable/blank strobe.
- `hub_addr`  in  4: row-pair address (dmux).
- `hub_rgb`  in  6: {b2,g2,r2,b1,g1,r1}; upper half is row addr+16, lower half is row addr.
- `err_clr`  in  1: synchronous clear of sticky error flags.
- `pix_valid`  out  1: pixel stream valid.
- `pix_ready`  in  1: downstream accept.
- `pix_x`  out  XW: column of the current pixel.
- `pix_row`  out  4: row-pair address latched with this row.
- `pix_rgb`  out  6: captured data for (pix_x, pix_row).
- `pix_sof`  out  1: high with pixel x=0 of row 0.
- `row_done`  out  1: one-cycle pulse after the last pixel of a row is accepted.
- `err_overrun`  out  1: sticky; a latch arrived while the previous row was still draining.
- `err_width`  out  1: sticky; a latch arrived with a column count other than WIDTH.
- `oe_pulses`  out  8: wrapping count of hub_oe rising edges.

## Operation
- **Input synchronisation.** All hub_* inputs pass through two flops. Edges are detected on the second stage against a third delayed copy.
- **Capture.**
  - On each hub_clk rising edge, write the synced hub_rgb to capture buffer[col_cnt] and increment col_cnt.
  - col_cnt saturates at WIDTH; further clocks are dropped but counted toward the width check.
  - The first shifted column is x=0.
- **Latch edge.**
  - If the drain FSM is IDLE: swap buffers, store the row address (synced hub_addr) and n = min(count, WIDTH), then enter DRAIN.
  - If the drain FSM is busy: set err_overrun and discard the row.
  - In either case, reset col_cnt to 0.
- **Simultaneous hub_clk and hub_latch edges.** The shift is applied first and is included in the row being latched.
- **Drain FSM, states IDLE and DRAIN.**
  - In DRAIN, pix_valid=1, with pix_x = index and pix_rgb = buffer[index].
  - The index advances only on pix_valid & pix_ready. Outputs hold stable while stalled.
  - After accepting index n-1, return to IDLE and pulse row_done on the next cycle.
  - If n=0: no pixels are emitted; go to IDLE and pulse row_done the cycle after the latch edge.
- **hub_oe.** A rising edge increments oe_pulses (wraps 255→0). hub_oe has no effect on capture.
- **Error flags.** err_clr clears both flags. If err_clr and a new error occur in the same cycle, the error wins.
- **Reset.** Asserting rst, including mid-row or mid-drain, drives every output to 0, empties both buffers' valid state, and sets the FSM to IDLE, col_cnt=0 and synchronisers to 0. Buffer contents are don't-care.

## Timing
- hub_latch pin rise → pix_valid high: 3 clk (2 sync + 1 register).
- hub_clk pin rise → buffer write: 3 clk.
- hub_rgb must be stable from 1 clk before to 3 clk after each hub_clk rise.
- hub_clk high and low phases must each be ≥ 2 clk.
- Drain throughput: 1 pixel/clk with pix_ready held high, so a full row drains in WIDTH clk.
- No overrun occurs if the latch spacing is ≥ WIDTH+2 clk with pix_ready held high.
- row_done occurs 1 clk after the final handshake.

## Configuration
- `HUB75_RX_WIDTH_CHECK_EN` defined: the width check is compiled in; err_width sets on any latch with count ≠ WIDTH.
- Not defined: err_width is tied to 0 and the counting logic beyond saturation is removed. Drain behaviour is identical either way.

## Test plan
- Shift 64 columns with rgb = x[5:0], addr=5, then latch, with pix_ready=1 → 64 pixels x=0..63, rgb=x, pix_row=5; row_done pulses once; no errors.
- Same stimulus with pix_ready toggling 1,0,1,0 → identical sequence, outputs held during stalls; row_done follows the 64th accept.
- Shift 10 columns, then latch (CHECK_EN defined) → 10 pixels; err_width=1; err_clr → 0. Without the macro → err_width stays 0.
- Latch row 0, hold pix_ready=0, then latch again → err_overrun=1, second row absent; pix_sof=1 on the first pixel.
- Assert rst at pixel 20 of a drain → pix_valid=0 and row_done=0 immediately. A new 64-column row after release drains correctly from x=0.
- Three hub_oe pulses after reset → oe_pulses=3. 256 pulses → oe_pulses wraps to 0.
